// File: rtl/vdc_pkg.sv
// vdc_pkg: shared types and constants for the VDC CPU bus front end.
//   - bus_state_t : forwarding FSM states
//   - REG_*       : register indices served by the downstream RAM interface
//   - ST_*        : bit positions inside the $D600 status byte
//   - bus_req_t   : one captured CPU access (register, data, direction)
//   - is_ram_reg  : true for registers whose value lives in the RAM interface
package vdc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_ISSUE  = 2'd2,
    S_SETTLE = 2'd3
  } bus_state_t;

  localparam logic [7:0] REG_UA_HI = 8'd18;
  localparam logic [7:0] REG_UA_LO = 8'd19;
  localparam logic [7:0] REG_COPY  = 8'd24;
  localparam logic [7:0] REG_WC    = 8'd30;
  localparam logic [7:0] REG_DA    = 8'd31;
  localparam logic [7:0] REG_BA_HI = 8'd32;
  localparam logic [7:0] REG_BA_LO = 8'd33;

  localparam int ST_READY  = 7;
  localparam int ST_LPF    = 6;
  localparam int ST_VBLANK = 5;

  typedef struct packed {
    logic [7:0] reg_a;
    logic [7:0] data;
    logic       we;
  } bus_req_t;

  function automatic logic is_ram_reg(input logic [7:0] a);
    return (a == REG_UA_HI) || (a == REG_UA_LO) || (a == REG_WC) ||
           (a == REG_DA)    || (a == REG_BA_HI) || (a == REG_BA_LO);
  endfunction

endpackage

// File: rtl/vdc_regfile.sv
// vdc_regfile: shadow copy of every non-RAM VDC register.
//   clk, reset, enable : clock, sync reset (qualified by enable), clock enable
//   wr                 : CPU write to $D601 this cycle
//   addr               : current register select
//   wdata              : CPU write data
//   rdata              : shadow value at addr, $FF beyond the implemented range
//   regs               : flattened register file, byte i = register i
module vdc_regfile
  import vdc_pkg::*;
#(
  parameter int NUM_REGS = 37
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [7:0]            addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [NUM_REGS*8-1:0] regs
);

  // One storage byte per register; RAM-interface registers never latch data
  // here and stay at zero, their read values come from the RAM interface.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] val_reg;
      logic       hit;

      assign hit = wr && (addr == 8'(gi)) && !is_ram_reg(8'(gi));

      always_ff @(posedge clk) begin
        if (enable) begin
          if (reset) begin
            val_reg <= 8'h00;
          end else if (hit) begin
            val_reg <= wdata;
          end
        end
      end

      assign regs[gi*8 +: 8] = val_reg;
    end
  endgenerate

  // Unmatched selects (>= NUM_REGS) fall through to the $FF default.
  always_comb begin
    rdata = 8'hFF;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 8'(i)) rdata = regs[i*8 +: 8];
    end
  end

endmodule

// File: rtl/vdc_busiface.sv
// vdc_busiface: CPU-side front end of the VDC.
//   clk, reset, enable        : clock, sync active-high reset, clock enable
//   enableBus, cs, rs, we     : CPU bus phase / chip select / $D600-$D601 / write
//   db_in, db_out             : CPU write data, registered CPU read data
//   vblank, lpf               : status flags reported at $D600
//   ram_busy, ram_ua, ram_wc,
//   ram_da, ram_ba            : state of the downstream RAM interface
//   f_enableBus, f_cs, f_rs,
//   f_we, f_regA, f_db        : one-enable-cycle strobe forwarded to the RAM interface
//   regs                      : flattened shadow register file
//   overrun                   : sticky, a deferred access was overwritten
module vdc_busiface
  import vdc_pkg::*;
#(
  parameter int         NUM_REGS = 37,
  parameter logic [2:0] VERSION  = 3'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  enableBus,
  input  logic                  cs,
  input  logic                  rs,
  input  logic                  we,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  input  logic                  vblank,
  input  logic                  lpf,
  input  logic                  ram_busy,
  input  logic [15:0]           ram_ua,
  input  logic [7:0]            ram_wc,
  input  logic [7:0]            ram_da,
  input  logic [15:0]           ram_ba,
  output logic                  f_enableBus,
  output logic                  f_cs,
  output logic                  f_rs,
  output logic                  f_we,
  output logic [7:0]            f_regA,
  output logic [7:0]            f_db,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  overrun
);

  bus_state_t state_reg, state_next;
  bus_req_t   hold_reg, issue_reg, cur_req;
  logic       hold_valid_reg;
  logic       overrun_reg;
  logic [7:0] reg_a_reg;
  logic [7:0] db_out_reg;
  logic       access, fwd_hit, ready;
  logic [7:0] shadow_rdata, status, rd_data;

  assign access  = enable & enableBus & cs;
  assign cur_req = '{reg_a: reg_a_reg, data: db_in, we: we};
  assign ready   = (state_reg == S_IDLE) & !ram_busy;

  // Writes to RAM registers and to the copy-mode register go downstream;
  // the only forwarded read is the data register, which auto-increments.
  assign fwd_hit = access & rs &
                   (we ? (is_ram_reg(reg_a_reg) | (reg_a_reg == REG_COPY))
                       : (reg_a_reg == REG_DA));

  vdc_regfile #(
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .wr    (access & rs & we),
    .addr  (reg_a_reg),
    .wdata (db_in),
    .rdata (shadow_rdata),
    .regs  (regs)
  );

  always_comb begin
    status            = 8'h00;
    status[ST_READY]  = ready;
    status[ST_LPF]    = lpf;
    status[ST_VBLANK] = vblank;
    status[2:0]       = VERSION;
  end

  always_comb begin
    case (reg_a_reg)
      REG_UA_HI: rd_data = ram_ua[15:8];
      REG_UA_LO: rd_data = ram_ua[7:0];
      REG_WC:    rd_data = ram_wc;
      REG_DA:    rd_data = ram_da;
      REG_BA_HI: rd_data = ram_ba[15:8];
      REG_BA_LO: rd_data = ram_ba[7:0];
      default:   rd_data = shadow_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (enable) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (fwd_hit) state_next = ram_busy ? S_HOLD : S_ISSUE;
      end
      S_HOLD: begin
        if (!ram_busy) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        // ram_busy is not trusted here: it still reflects the pre-strobe cycle.
        state_next = (hold_valid_reg | fwd_hit) ? S_HOLD : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs, strobe only while issuing
  always_comb begin
    f_enableBus = 1'b0;
    f_cs        = 1'b0;
    f_rs        = 1'b0;
    f_we        = 1'b0;
    f_regA      = 8'h00;
    f_db        = 8'h00;
    if (state_reg == S_ISSUE) begin
      f_enableBus = 1'b1;
      f_cs        = 1'b1;
      f_rs        = 1'b1;
      f_we        = issue_reg.we;
      f_regA      = issue_reg.reg_a;
      f_db        = issue_reg.data;
    end
  end

  // Datapath: register select, read data, hold/issue buffers, overrun flag
  always_ff @(posedge clk) begin
    if (enable) begin
      if (reset) begin
        reg_a_reg      <= 8'h00;
        db_out_reg     <= 8'h00;
        overrun_reg    <= 1'b0;
        hold_valid_reg <= 1'b0;
        hold_reg       <= '0;
        issue_reg      <= '0;
      end else begin
        if (access && !rs && we) reg_a_reg <= {2'b00, db_in[5:0]};

        if (access && !we) db_out_reg <= rs ? rd_data : status;

        case (state_reg)
          S_IDLE: begin
            if (fwd_hit) begin
              if (ram_busy) begin
                hold_reg       <= cur_req;
                hold_valid_reg <= 1'b1;
              end else begin
                issue_reg <= cur_req;
              end
            end
          end
          S_HOLD: begin
            if (fwd_hit) overrun_reg <= 1'b1;
            if (!ram_busy) begin
              // A fresh access supersedes the buffered one.
              issue_reg      <= fwd_hit ? cur_req : hold_reg;
              hold_valid_reg <= 1'b0;
            end else if (fwd_hit) begin
              hold_reg <= cur_req;
            end
          end
          default: begin
            if (fwd_hit) begin
              if (hold_valid_reg) overrun_reg <= 1'b1;
              hold_reg       <= cur_req;
              hold_valid_reg <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign db_out  = db_out_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_vdc_busiface.sv
// tb_vdc_busiface: directed self-checking bench for vdc_busiface.
module tb_vdc_busiface;
  import vdc_pkg::*;

  localparam int NUM_REGS = 37;

  logic                  clk = 1'b0;
  logic                  reset, enable, enableBus, cs, rs, we;
  logic [7:0]            db_in, db_out;
  logic                  vblank, lpf, ram_busy;
  logic [15:0]           ram_ua, ram_ba;
  logic [7:0]            ram_wc, ram_da;
  logic                  f_enableBus, f_cs, f_rs, f_we;
  logic [7:0]            f_regA, f_db;
  logic [NUM_REGS*8-1:0] regs;
  logic                  overrun;

  int tests = 0;
  int fails = 0;

  vdc_busiface #(.NUM_REGS(NUM_REGS), .VERSION(3'd2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .enableBus(enableBus),
    .cs(cs), .rs(rs), .we(we), .db_in(db_in), .db_out(db_out),
    .vblank(vblank), .lpf(lpf), .ram_busy(ram_busy), .ram_ua(ram_ua),
    .ram_wc(ram_wc), .ram_da(ram_da), .ram_ba(ram_ba),
    .f_enableBus(f_enableBus), .f_cs(f_cs), .f_rs(f_rs), .f_we(f_we),
    .f_regA(f_regA), .f_db(f_db), .regs(regs), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU bus cycle; outputs are sampled 1 time unit after the edge.
  task automatic bus(input logic r, input logic w, input logic [7:0] d);
    enableBus = 1'b1; cs = 1'b1; rs = r; we = w; db_in = d;
    @(posedge clk); #1;
    enableBus = 1'b0; cs = 1'b0; we = 1'b0;
    $display("[TB] bus rs=%0d we=%0d db_in=%h -> db_out=%h f_en=%0d f_regA=%h f_db=%h",
             r, w, d, db_out, f_enableBus, f_regA, f_db);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; enableBus = 1'b0; cs = 1'b0; rs = 1'b0;
    we = 1'b0; db_in = 8'h00; vblank = 1'b0; lpf = 1'b0; ram_busy = 1'b0;
    ram_ua = 16'hBEEF; ram_wc = 8'h11; ram_da = 8'h9A; ram_ba = 16'h1234;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_db_out",  db_out, 8'h00);
    chk("rst_overrun", 8'(overrun), 8'd0);
    chk("rst_f_en",    8'(f_enableBus), 8'd0);
    chk("rst_regs",    8'(regs == '0), 8'd1);

    // Shadow register path, reg 28
    bus(1'b0, 1'b1, 8'h1C);
    bus(1'b1, 1'b0, 8'h00);
    chk("r28_reset_val", db_out, 8'h00);
    bus(1'b1, 1'b1, 8'h5A);
    chk("r28_no_fwd", 8'(f_enableBus), 8'd0);
    bus(1'b1, 1'b0, 8'h00);
    chk("r28_readback", db_out, 8'h5A);
    chk("r28_regs", regs[28*8 +: 8], 8'h5A);
    enable = 1'b0;
    bus(1'b0, 1'b1, 8'h00);       // ignored: clock enable low
    enable = 1'b1;
    bus(1'b1, 1'b0, 8'h00);
    chk("enable_gate", db_out, 8'h5A);

    // Status
    vblank = 1'b1;
    bus(1'b0, 1'b0, 8'h00);
    chk("status_ready", db_out, 8'hA2);
    ram_busy = 1'b1;
    bus(1'b0, 1'b0, 8'h00);
    chk("status_busy", db_out, 8'h22);
    ram_busy = 1'b0;

    // Unblocked forwarded write to reg 18
    bus(1'b0, 1'b1, 8'h12);
    bus(1'b1, 1'b1, 8'h40);
    chk("fw18_en",   8'(f_enableBus), 8'd1);
    chk("fw18_cs",   8'(f_cs), 8'd1);
    chk("fw18_rs",   8'(f_rs), 8'd1);
    chk("fw18_we",   8'(f_we), 8'd1);
    chk("fw18_regA", f_regA, 8'h12);
    chk("fw18_db",   f_db, 8'h40);
    chk("fw18_noshadow", regs[18*8 +: 8], 8'h00);
    idle();
    chk("fw18_one_cycle", 8'(f_enableBus), 8'd0);
    idle();

    // Copy-mode register: forwarded and shadowed
    bus(1'b0, 1'b1, 8'h18);
    bus(1'b1, 1'b1, 8'h80);
    chk("fw24_en",   8'(f_enableBus), 8'd1);
    chk("fw24_regA", f_regA, 8'h18);
    chk("fw24_shadow", regs[24*8 +: 8], 8'h80);
    idle();
    idle();

    // Deferred write while busy, then overwrite
    ram_busy = 1'b1;
    bus(1'b0, 1'b1, 8'h1F);
    bus(1'b1, 1'b1, 8'h55);
    chk("hold_no_strobe", 8'(f_enableBus), 8'd0);
    chk("hold_no_overrun", 8'(overrun), 8'd0);
    bus(1'b0, 1'b0, 8'h00);
    chk("hold_status", db_out, 8'h22);
    bus(1'b1, 1'b1, 8'h66);
    chk("hold_overrun", 8'(overrun), 8'd1);
    chk("hold_still_quiet", 8'(f_enableBus), 8'd0);
    ram_busy = 1'b0;
    idle();
    chk("rel_en",   8'(f_enableBus), 8'd1);
    chk("rel_regA", f_regA, 8'h1F);
    chk("rel_db",   f_db, 8'h66);
    chk("rel_we",   8'(f_we), 8'd1);
    idle();
    chk("rel_settle", 8'(f_enableBus), 8'd0);
    idle();
    chk("rel_no_second", 8'(f_enableBus), 8'd0);

    // Out-of-range register
    bus(1'b0, 1'b1, 8'h28);
    bus(1'b1, 1'b1, 8'h12);
    chk("r40_no_fwd", 8'(f_enableBus), 8'd0);
    bus(1'b1, 1'b0, 8'h00);
    chk("r40_read_ff", db_out, 8'hFF);
    chk("r40_read_no_fwd", 8'(f_enableBus), 8'd0);

    // Forwarded read of reg 31 plus RAM-side read mux
    bus(1'b0, 1'b1, 8'h1F);
    bus(1'b1, 1'b0, 8'h00);
    chk("r31_db_out", db_out, 8'h9A);
    chk("r31_f_en",   8'(f_enableBus), 8'd1);
    chk("r31_f_we",   8'(f_we), 8'd0);
    chk("r31_f_regA", f_regA, 8'h1F);
    idle();
    idle();
    bus(1'b0, 1'b1, 8'h12);
    bus(1'b1, 1'b0, 8'h00);
    chk("r18_ua_hi", db_out, 8'hBE);
    chk("r18_read_no_fwd", 8'(f_enableBus), 8'd0);
    bus(1'b0, 1'b1, 8'h21);
    bus(1'b1, 1'b0, 8'h00);
    chk("r33_ba_lo", db_out, 8'h34);
    bus(1'b0, 1'b1, 8'h1E);
    bus(1'b1, 1'b0, 8'h00);
    chk("r30_wc", db_out, 8'h11);

    // Reset while holding
    ram_busy = 1'b1;
    bus(1'b0, 1'b1, 8'h1F);
    bus(1'b1, 1'b1, 8'h77);
    bus(1'b1, 1'b1, 8'h78);
    chk("pre_rst_overrun", 8'(overrun), 8'd1);
    reset = 1'b1;
    ram_busy = 1'b0;
    idle();
    chk("mid_rst_f_en",    8'(f_enableBus), 8'd0);
    chk("mid_rst_overrun", 8'(overrun), 8'd0);
    chk("mid_rst_db_out",  db_out, 8'h00);
    chk("mid_rst_regs",    8'(regs == '0), 8'd1);
    reset = 1'b0;
    idle();
    chk("post_rst_f_en1", 8'(f_enableBus), 8'd0);
    idle();
    chk("post_rst_f_en2", 8'(f_enableBus), 8'd0);
    bus(1'b0, 1'b0, 8'h00);
    chk("post_rst_status", db_out, 8'hA2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vdc_busiface.md
Name: vdc_busiface

Overview:
- CPU-side front end of the VDC. It decodes $D600 (address/status) and $D601 (data) accesses and holds the register-select latch.
- It owns the shadow register file for all non-RAM registers and composes CPU read data.
- It forwards RAM-related accesses (regs 18,19,30,31,32,33) to the downstream RAM interface as single-enable-cycle strobes.
- If that interface is busy, it defers the access in a one-deep hold buffer until the interface is ready.

Parameters:
- NUM_REGS, 37, number of implemented registers (0..NUM_REGS-1); higher indices read $FF and ignore writes.
- VERSION, 3'd2, version code reported in status bits 2:0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  clock enable; all state advances only when high
- enableBus  in  1  CPU bus phase valid
- cs  in  1  VDC chip select
- rs  in  1  0=$D600, 1=$D601
- we  in  1  1=CPU write
- db_in  in  8  CPU write data
- db_out  out  8  CPU read data (registered)
- vblank  in  1  vertical blank flag from display timing
- lpf  in  1  light-pen strobe-latched flag
- ram_busy  in  1  busy from RAM interface
- ram_ua  in  16  update address from RAM interface
- ram_wc  in  8  word count from RAM interface
- ram_da  in  8  data latch from RAM interface
- ram_ba  in  16  block address from RAM interface
- f_enableBus, f_cs, f_rs, f_we  out  1 each  forwarded strobe to RAM interface
- f_regA  out  8  forwarded register select
- f_db  out  8  forwarded write data
- regs  out  NUM_REGS*8  flattened shadow register file, for display/timing blocks
- overrun  out  1  sticky: a deferred access was overwritten

Behaviour:
- Reset (applied when reset and enable are both high):
  - regA=0; all shadow regs=0; db_out=0; overrun=0.
  - All f_* outputs=0; FSM to S_IDLE; hold buffer empty.
- Access = enable & enableBus & cs, sampled on clk. Only the access cycle itself counts; the CPU holds no handshake.
- rs=0 write: regA <= {2'b00, db_in[5:0]}. Nothing is forwarded.
- rs=0 read: db_out <= {ready, lpf, vblank, 2'b00, VERSION}.
  - ready = (state==S_IDLE) & !ram_busy.
- rs=1 write:
  - If regA < NUM_REGS and regA is not in {18,19,30,31,32,33}, write the shadow reg.
  - Forward it if regA is in that set, or regA==24. Reg 24 bit7 selects copy mode downstream, so it is also shadowed.
- rs=1 read:
  - For regs 18/19/30/31/32/33, db_out returns ram_ua[15:8] / ram_ua[7:0] / ram_wc / ram_da / ram_ba[15:8] / ram_ba[7:0].
  - Other regs < NUM_REGS return the shadow value; regA >= NUM_REGS returns $FF.
  - A read of reg 31 is also forwarded (auto-increment). db_out carries the pre-increment ram_da.
- Forwarding FSM (transitions only on enable):
  - S_IDLE:
    - Forwardable access with !ram_busy goes to S_ISSUE.
    - With ram_busy, latch {regA, db_in, we} into the hold buffer and go to S_HOLD.
  - S_HOLD:
    - Wait for !ram_busy, then go to S_ISSUE with the buffered access.
    - A new forwardable access in S_HOLD overwrites the buffer and sets overrun=1.
  - S_ISSUE:
    - Drive f_enableBus=f_cs=f_rs=1, f_we, f_regA, f_db for exactly one enable cycle, then go to S_SETTLE.
  - S_SETTLE:
    - One enable cycle ignoring ram_busy (downstream busy is registered and lags by one cycle), then go to S_IDLE.
    - A forwardable access arriving in S_ISSUE/S_SETTLE goes to the hold buffer; state returns to S_HOLD after S_SETTLE.
- f_* outputs are 0 in every state other than S_ISSUE.
- Latency: an unblocked write reaches f_* on the next enable cycle (1 enable cycle).
- Non-forwardable accesses are never blocked and complete in the access cycle in every state.
- overrun clears only on reset.
- Reset mid-operation: the hold buffer is discarded and no strobe is issued on the reset cycle.

Decomposition:
- Package vdc_pkg holds:
  - the bus FSM state enum (S_IDLE, S_HOLD, S_ISSUE, S_SETTLE);
  - the RAM-register index constants (REG_UA_HI=18, REG_UA_LO=19, REG_WC=30, REG_DA=31, REG_BA_HI=32, REG_BA_LO=33, REG_COPY=24);
  - the status bit positions.
- One natural sub-module: vdc_regfile (shadow storage, write-enable decode and read mux, with the $FF default).

Test Plan:
- After reset: write $D600=$1C, read $D601 -> $00; read $D600 with ram_busy=0, vblank=1 -> $A2.
- Write $D600=$12, write $D601=$40 with ram_busy=0 -> f_regA=18, f_db=$40, f_we=1 for exactly one enable cycle, on the next enable cycle.
- Hold ram_busy=1, write reg 31=$55 -> status bit7=0, no strobe; release ram_busy -> strobe regA=31, db=$55 one enable cycle later.
- While held, write reg 31=$66 -> overrun=1 and only $66 is forwarded.
- Write reg 40=$12 with NUM_REGS=37 -> read returns $FF, nothing forwarded.
- Read reg 31 with ram_da=$9A -> db_out=$9A and one forwarded read strobe (f_we=0).
- Assert reset while in S_HOLD -> no strobe; state S_IDLE; overrun=0.
